// File: rtl/add_serial_pkg.sv
// Shared types and defaults for the round-robin scheduler around the bit-serial adder.
package add_serial_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Carry of a full adder: majority of the three inputs.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/add_serial_core.sv
// Bit-serial adder datapath: operand shift registers, carry, bit counter, result shift register.
module add_serial_core
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sum_bit_s;

  // sum/cout include the bit computed this cycle, so on the final step they are the complete result.
  assign sum_bit_s = a_r[0] ^ b_r[0] ^ carry_r;
  assign sum       = {sum_bit_s, res_r[WIDTH-1:1]};
  assign cout      = maj3(a_r[0], b_r[0], carry_r);
  assign last      = (cnt_r == CNT_W'(WIDTH - 1));

  // Operand capture on load, one LSB-first add step per step cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (load) begin
      a_r     <= a;
      b_r     <= b;
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (step) begin
      a_r     <= a_r >> 1;
      b_r     <= b_r >> 1;
      res_r   <= sum;
      carry_r <= cout;
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder between N_REQ requesters.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout
);

  state_e             state_r;
  state_e             next_s;
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    win_r;
  logic [ID_W-1:0]    win_s;
  logic [ID_W-1:0]    idx_s;
  logic               found_s;
  logic               hit_s;
  logic               load_s;
  logic               step_s;
  logic               last_s;
  logic [WIDTH-1:0]   core_sum_s;
  logic               core_cout_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [N_REQ-1:0]   gnt_r;
  logic               busy_r;
  logic               done_r;
  logic [ID_W-1:0]    done_id_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  // Rotating-priority search: first pending request at or after ptr_r.
  always_comb begin
    win_s   = {ID_W{1'b0}};
    idx_s   = {ID_W{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s   = ID_W'((int'(ptr_r) + k) % N_REQ);
      hit_s   = !found_s && req[idx_s];
      win_s   = hit_s ? idx_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  assign a_sel_s = a_in[win_s*WIDTH +: WIDTH];
  assign b_sel_s = b_in[win_s*WIDTH +: WIDTH];

  add_serial_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .step (step_s),
    .a    (a_sel_s),
    .b    (b_sel_s),
    .last (last_s),
    .sum  (core_sum_s),
    .cout (core_cout_s)
  );

  // Next-state and core controls; operands are captured while still in IDLE.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          next_s = LOAD;
          load_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      LOAD: next_s = ADD;
      ADD: begin
        step_s = 1'b1;
        if (last_s) begin
          next_s = DONE;
        end else begin
          next_s = ADD;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State, arbitration pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      ptr_r     <= {ID_W{1'b0}};
      win_r     <= {ID_W{1'b0}};
      gnt_r     <= {N_REQ{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= {ID_W{1'b0}};
      sum_r     <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != IDLE);
      gnt_r   <= load_s ? (N_REQ'(1'b1) << win_s) : {N_REQ{1'b0}};
      done_r  <= (state_r == ADD) && last_s;
      if (load_s) begin
        win_r <= win_s;
      end
      if ((state_r == ADD) && last_s) begin
        sum_r     <= core_sum_s;
        cout_r    <= core_cout_s;
        done_id_r <= win_r;
      end
      if (state_r == DONE) begin
        ptr_r <= (win_r == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : win_r + ID_W'(1);
      end
    end
  end

  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign sum     = sum_r;
  assign cout    = cout_r;

endmodule

// File: tb/tb_add_serial_sched.sv
// Directed and randomized self-checking bench for add_serial_sched (N_REQ=4, WIDTH=8).
module tb_add_serial_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [WIDTH-1:0]       sum;
  logic                   cout;

  int n_chk = 0;
  int n_err = 0;

  int g_id[$];
  int g_cyc[$];
  int d_id[$];
  int d_sum[$];
  int d_cout[$];
  int d_cyc[$];

  add_serial_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, " gnt"},     32'(gnt),     32'd0);
    check_eq({tag, " busy"},    32'(busy),    32'd0);
    check_eq({tag, " done"},    32'(done),    32'd0);
    check_eq({tag, " done_id"}, 32'(done_id), 32'd0);
    check_eq({tag, " sum"},     32'(sum),     32'd0);
    check_eq({tag, " cout"},    32'(cout),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b);
    a_in[r*WIDTH +: WIDTH] = a;
    b_in[r*WIDTH +: WIDTH] = b;
    req[r] = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  // One isolated operation with exact cycle checks: gnt in cycle 1, done in cycle 10.
  task automatic run_directed(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] esum, input logic ecout);
    @(negedge clk);
    set_op(r, a, b);
    @(negedge clk);
    check_eq({tag, " gnt"},  32'(gnt),  32'(4'b0001 << r));
    check_eq({tag, " busy"}, 32'(busy), 32'd1);
    req[r] = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      check_eq({tag, " early done"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    check_eq({tag, " done"},    32'(done),    32'd1);
    check_eq({tag, " sum"},     32'(sum),     32'(esum));
    check_eq({tag, " cout"},    32'(cout),    32'(ecout));
    check_eq({tag, " done_id"}, 32'(done_id), 32'(r));
    @(negedge clk);
    check_eq({tag, " done pulse"}, 32'(done), 32'd0);
    check_eq({tag, " busy low"},   32'(busy), 32'd0);
    check_eq({tag, " sum hold"},   32'(sum),  32'(esum));
  endtask

  // Record grant and done events for ncyc cycles; cycle 1 is the first after the call.
  task automatic collect(input int ncyc);
    g_id.delete(); g_cyc.delete();
    d_id.delete(); d_sum.delete(); d_cout.delete(); d_cyc.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_id.push_back(oh2idx(gnt));
        g_cyc.push_back(c);
      end
      if (done) begin
        d_id.push_back(int'(done_id));
        d_sum.push_back(int'(sum));
        d_cout.push_back(int'(cout));
        d_cyc.push_back(c);
      end
    end
  endtask

  logic [7:0] exp_sum [4] = '{8'h00, 8'h10, 8'h80, 8'hFF};
  logic       exp_cout[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst  = 1'b0;
    req  = '0;
    a_in = '0;
    b_in = '0;
    #2;
    check_zero_outputs("power-on reset");
    do_reset();

    run_directed("single", 0, 8'h0F, 8'h01, 8'h10, 1'b0);
    run_directed("overflow", 2, 8'hFF, 8'h01, 8'h00, 1'b1);

    // All four requesters held continuously.
    do_reset();
    @(negedge clk);
    a_in = {8'h01, 8'h7F, 8'hC0, 8'h80};
    b_in = {8'hFE, 8'h01, 8'h50, 8'h80};
    req  = 4'b1111;
    collect(55);
    check_eq("all4 gnt count",  32'(g_id.size()), 32'd5);
    check_eq("all4 done count", 32'(d_id.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq("all4 gnt order", 32'((i < g_id.size()) ? g_id[i] : -1), 32'(i % 4));
      check_eq("all4 done_id",   32'((i < d_id.size()) ? d_id[i] : -1), 32'(i % 4));
      check_eq("all4 sum",       32'((i < d_sum.size()) ? d_sum[i] : -1), 32'(exp_sum[i % 4]));
      check_eq("all4 cout",      32'((i < d_cout.size()) ? d_cout[i] : -1), 32'(exp_cout[i % 4]));
    end
    check_eq("all4 first done cycle", 32'((d_cyc.size() > 0) ? d_cyc[0] : -1), 32'd10);
    for (int i = 1; i < 5; i++) begin
      check_eq("all4 done spacing",
               32'((i < d_cyc.size()) ? d_cyc[i] - d_cyc[i-1] : -1), 32'd11);
    end
    req = '0;
    wait_idle("all4");

    // Requesters 1 and 3 held continuously must alternate.
    do_reset();
    @(negedge clk);
    req = 4'b1010;
    collect(44);
    check_eq("alt gnt count", 32'(g_id.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("alt gnt order", 32'((i < g_id.size()) ? g_id[i] : -1), (i % 2 == 0) ? 32'd1 : 32'd3);
      check_eq("alt done_id",   32'((i < d_id.size()) ? d_id[i] : -1), (i % 2 == 0) ? 32'd1 : 32'd3);
      check_eq("alt sum", 32'((i < d_sum.size()) ? d_sum[i] : -1),
               (i % 2 == 0) ? 32'h10 : 32'hFF);
    end
    req = '0;
    wait_idle("alt");

    // Reset in cycle 5 of an operation; pointer first moved to 3 so a stale pointer would favour 3.
    do_reset();
    run_directed("pre-abort", 2, 8'h05, 8'h03, 8'h08, 1'b0);
    @(negedge clk);
    set_op(3, 8'h12, 8'h34);
    @(negedge clk);
    check_eq("abort gnt", 32'(gnt), 32'b1000);
    req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero_outputs("abort reset");
    set_op(1, 8'h21, 8'h43);
    set_op(3, 8'h21, 8'h43);
    repeat (2) @(negedge clk);
    check_zero_outputs("abort held");
    rst = 1'b1;
    collect(11);
    check_eq("abort gnt count",  32'(g_id.size()), 32'd1);
    check_eq("abort first gnt",  32'((g_id.size() > 0) ? g_id[0] : -1), 32'd1);
    check_eq("abort gnt cycle",  32'((g_cyc.size() > 0) ? g_cyc[0] : -1), 32'd1);
    check_eq("abort done count", 32'(d_id.size()), 32'd1);
    check_eq("abort done cycle", 32'((d_cyc.size() > 0) ? d_cyc[0] : -1), 32'd10);
    check_eq("abort done_id",    32'((d_id.size() > 0) ? d_id[0] : -1), 32'd1);
    check_eq("abort sum",        32'((d_sum.size() > 0) ? d_sum[0] : -1), 32'h64);
    req = '0;
    wait_idle("abort");

    // Random operands on random single requesters.
    for (int n = 0; n < 1000; n++) begin
      int         r;
      int         k;
      int         extra;
      logic [7:0] ra;
      logic [7:0] rb;
      logic [8:0] full;
      r    = $urandom_range(0, N_REQ - 1);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      full = {1'b0, ra} + {1'b0, rb};
      set_op(r, ra, rb);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (gnt == '0 && k < 5);
      check_eq("rnd gnt", 32'(gnt), 32'(4'b0001 << r));
      req = '0;
      k = 0;
      extra = 0;
      do begin
        @(negedge clk);
        k++;
        if (gnt != '0) extra++;
      end while (!done && k < 20);
      check_eq("rnd done",      32'(done),    32'd1);
      check_eq("rnd extra gnt", 32'(extra),   32'd0);
      check_eq("rnd done_id",   32'(done_id), 32'(r));
      check_eq("rnd sum",       32'(sum),     32'(full[7:0]));
      check_eq("rnd cout",      32'(cout),    32'(full[8]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
